plusarg_watchdog: RTL and testbench

Simulation watchdog that consumes the value produced by a `plusarg_reader` instance, for example `+max_core_cycles=%d`, and flags a timeout when no forward progress is reported within that many (optionally prescaled) cycles. It sits directly downstream of the plusarg reader in test harnesses. Its `fire` and `expired` outputs drive the harness's stop/assert logic. A limit of zero disables the watchdog, which is the usual plusarg DEFAULT.

---
 rtl/plusarg_watchdog.sv | 89 ++++++++
 tb/tb_plusarg_watchdog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/plusarg_watchdog.sv
// plusarg_watchdog: simulation watchdog fed by a plusarg_reader limit value.
// Ports:
//   clock   - sole clock, rising edge
//   reset   - synchronous, active-low reset
//   limit   - timeout in (prescaled) counts, captured once on reset release; 0 disables
//   kick    - progress indication, clears count and prescaler
//   pause   - freezes prescaler and counter
//   count   - current count (registered)
//   warn    - approaching-timeout flag (registered)
//   fire    - single-cycle timeout pulse (registered)
//   expired - sticky timeout flag (registered)
module plusarg_watchdog #(
    parameter int WIDTH       = 32,
    parameter int PRESCALE    = 0,
    parameter int WARN_MARGIN = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    input  logic             kick,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             warn,
    output logic             fire,
    output logic             expired
);
    localparam int PW = PRESCALE > 0 ? PRESCALE : 1;
    localparam logic [PW-1:0] PMAX = PW'((64'd1 << PRESCALE) - 64'd1);
    localparam logic [1:0] ST_RST = 2'd0;
    localparam logic [1:0] ST_DIS = 2'd1;
    localparam logic [1:0] ST_ARM = 2'd2;
    localparam logic [1:0] ST_EXP = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] limit_q;
    logic [PW-1:0]    pre;
    logic             tick_en;
    logic             adv;
    logic             hit;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] thresh;
    logic [PW-1:0]    pre_nx;
    logic             warn_nx;

    always_comb begin
        tick_en  = (PRESCALE == 0) || (pre == PMAX);
        adv      = !kick && !pause;
        cnt_inc  = count + 1'b1;
        count_nx = kick ? '0 : (adv && tick_en) ? cnt_inc : count;
        // a tick lands on the all-ones prescaler value, so clearing equals wrapping
        pre_nx   = (kick || (adv && tick_en)) ? '0 : adv ? pre + 1'b1 : pre;
        // count only ever steps by one from below limit_q, so equality is the expiry test
        hit      = adv && tick_en && (cnt_inc == limit_q);
        thresh   = (limit_q > WIDTH'(WARN_MARGIN)) ? limit_q - WIDTH'(WARN_MARGIN) : '0;
        warn_nx  = (WARN_MARGIN != 0) && !hit && (count_nx >= thresh);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_RST;
            count   <= '0;
            pre     <= '0;
            limit_q <= '0;
            warn    <= 1'b0;
            fire    <= 1'b0;
            expired <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    limit_q <= limit;
                    state   <= (limit == '0) ? ST_DIS : ST_ARM;
                end
                ST_ARM: begin
                    count <= count_nx;
                    pre   <= pre_nx;
                    warn  <= warn_nx;
                    if (hit) begin
                        state   <= ST_EXP;
                        fire    <= 1'b1;
                        expired <= 1'b1;
                    end
                end
                ST_EXP: fire <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_plusarg_watchdog.sv
// tb_plusarg_watchdog: self-checking bench for plusarg_watchdog against a counting model.
module tb_plusarg_watchdog;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        ra = 1'b0, ka = 1'b0, pa = 1'b0;
    logic [31:0] la = '0;
    logic [31:0] ca;
    logic        wa, fa, ea;
    logic        rb = 1'b0, kb = 1'b0, pb = 1'b0;
    logic [31:0] lb = '0;
    logic [31:0] cb;
    logic        wb, fb, eb;
    logic        rc = 1'b0, kc = 1'b0, pc = 1'b0;
    logic [3:0]  lc = '0;
    logic [3:0]  cc;
    logic        wc, fc, ec;

    int n_cmp = 0;
    int n_bad = 0;

    plusarg_watchdog #(.WIDTH(32), .PRESCALE(0), .WARN_MARGIN(3)) dut_a (
        .clock(clock), .reset(ra), .limit(la), .kick(ka), .pause(pa),
        .count(ca), .warn(wa), .fire(fa), .expired(ea));
    plusarg_watchdog #(.WIDTH(32), .PRESCALE(2), .WARN_MARGIN(1)) dut_b (
        .clock(clock), .reset(rb), .limit(lb), .kick(kb), .pause(pb),
        .count(cb), .warn(wb), .fire(fb), .expired(eb));
    plusarg_watchdog #(.WIDTH(4), .PRESCALE(0), .WARN_MARGIN(0)) dut_c (
        .clock(clock), .reset(rc), .limit(lc), .kick(kc), .pause(pc),
        .count(cc), .warn(wc), .fire(fc), .expired(ec));

    // Model: count = (unpaused cycles since last kick) / 2^P, stopping at the limit.
    longint mc[3], mrun[3], mlim[3];
    bit     ms[3], md[3], me[3], mf[3], mw[3];

    task automatic model(input int i, input int p, input longint m, input bit r,
                         input bit k, input bit ps, input longint l);
        longint thr;
        if (!r) begin
            ms[i] = 0; md[i] = 0; me[i] = 0; mf[i] = 0; mw[i] = 0; mc[i] = 0; mrun[i] = 0;
        end else if (!ms[i]) begin
            ms[i] = 1; mlim[i] = l; md[i] = (l == 0);
        end else if (!md[i]) begin
            if (me[i]) mf[i] = 0;
            else begin
                if (k) mrun[i] = 0;
                else if (!ps) mrun[i]++;
                mc[i] = mrun[i] >> p;
                thr = (mlim[i] > m) ? mlim[i] - m : 0;
                if (mc[i] == mlim[i]) begin
                    me[i] = 1; mf[i] = 1; mw[i] = 0;
                end else mw[i] = (m != 0) && (mc[i] >= thr);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model(0, 0, 3, ra, ka, pa, longint'(la));
        model(1, 2, 1, rb, kb, pb, longint'(lb));
        model(2, 0, 0, rc, kc, pc, longint'(lc));
        #1;
    endtask

    task automatic restart(input int i, input longint l);
        if (i == 0) begin ra = 0; ka = 0; pa = 0; end
        else if (i == 1) begin rb = 0; kb = 0; pb = 0; end
        else begin rc = 0; kc = 0; pc = 0; end
        tick();
        tick();
        if (i == 0) begin la = 32'(l); ra = 1; end
        else if (i == 1) begin lb = 32'(l); rb = 1; end
        else begin lc = 4'(l); rc = 1; end
    endtask

    task automatic test_reset();
        ra = 0; rb = 0; rc = 0; la = 9; lb = 9; lc = 9;
        for (int n = 0; n < 4; n++) begin
            ka = 1'($urandom); pa = 1'($urandom); kb = 1'($urandom); kc = 1'($urandom);
            tick();
            n_cmp++;
            if ({ca, wa, fa, ea} !== 35'd0) begin n_bad++; $display("FAIL reset_a: got %h want 0", {ca, wa, fa, ea}); end
            n_cmp++;
            if ({cb, wb, fb, eb} !== 35'd0) begin n_bad++; $display("FAIL reset_b: got %h want 0", {cb, wb, fb, eb}); end
            n_cmp++;
            if ({cc, wc, fc, ec} !== 7'd0) begin n_bad++; $display("FAIL reset_c: got %h want 0", {cc, wc, fc, ec}); end
        end
        ka = 0; kb = 0; kc = 0; pa = 0;
    endtask

    task automatic test_basic();
        restart(0, 5);
        tick();
        n_cmp++;
        if (ca !== 32'd0) begin n_bad++; $display("FAIL basic_e0: count got %0d want 0", ca); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if ({ca, fa, ea} !== {32'(i), i == 5, i == 5})
                begin n_bad++; $display("FAIL basic_e%0d: count/fire/exp got %0d/%b/%b", i, ca, fa, ea); end
        end
        for (int i = 0; i < 21; i++) begin
            tick();
            n_cmp++;
            if ({ca, fa, ea} !== {32'd5, 1'b0, 1'b1})
                begin n_bad++; $display("FAIL basic_hold: count/fire/exp got %0d/%b/%b want 5/0/1", ca, fa, ea); end
            n_cmp++;
            if ({ca, wa, fa, ea} !== {mc[0][31:0], mw[0], mf[0], me[0]})
                begin n_bad++; $display("FAIL basic_model: got %h want %h", {ca, wa, fa, ea}, {mc[0][31:0], mw[0], mf[0], me[0]}); end
        end
    endtask

    task automatic test_disabled();
        restart(0, 0);
        tick();
        la = 7;
        for (int i = 0; i < 1000; i++) begin
            ka = 1'($urandom); pa = 1'($urandom);
            tick();
            n_cmp++;
            if ({ca, wa, fa, ea} !== 35'd0) begin n_bad++; $display("FAIL disabled: got %h want 0", {ca, wa, fa, ea}); end
        end
        ka = 0; pa = 0;
    endtask

    task automatic test_kick_race();
        restart(0, 4);
        repeat (4) tick();
        n_cmp++;
        if (ca !== 32'd3) begin n_bad++; $display("FAIL race_pre: count got %0d want 3", ca); end
        ka = 1;
        tick();
        ka = 0;
        n_cmp++;
        if ({ca, fa, ea} !== 34'd0) begin n_bad++; $display("FAIL race_kick: count/fire/exp got %0d/%b/%b want 0/0/0", ca, fa, ea); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if ({ca, fa} !== {32'(i), i == 4}) begin n_bad++; $display("FAIL race_after%0d: count/fire got %0d/%b", i, ca, fa); end
        end
        ka = 1;
        tick();
        ka = 0;
        n_cmp++;
        if ({ca, fa, ea} !== {32'd4, 1'b0, 1'b1})
            begin n_bad++; $display("FAIL race_expired_kick: count/fire/exp got %0d/%b/%b want 4/0/1", ca, fa, ea); end
    endtask

    task automatic test_prescale_warn();
        restart(1, 3);
        tick();
        for (int e = 1; e <= 13; e++) begin
            tick();
            n_cmp++;
            if ({cb, fb, wb} !== {32'(e < 12 ? e / 4 : 3), e == 12, e >= 8 && e < 12})
                begin n_bad++; $display("FAIL presc_e%0d: count/fire/warn got %0d/%b/%b", e, cb, fb, wb); end
        end
        restart(1, 3);
        tick();
        for (int e = 1; e <= 23; e++) begin
            pb = (e >= 5 && e <= 14);
            tick();
            n_cmp++;
            if (fb !== (e == 22)) begin n_bad++; $display("FAIL pause_fire_e%0d: got %b want %b", e, fb, e == 22); end
            n_cmp++;
            if ({cb, wb, fb, eb} !== {mc[1][31:0], mw[1], mf[1], me[1]})
                begin n_bad++; $display("FAIL pause_model_e%0d: got %h want %h", e, {cb, wb, fb, eb}, {mc[1][31:0], mw[1], mf[1], me[1]}); end
        end
        pb = 0;
    endtask

    task automatic test_reset_mid();
        restart(0, 3);
        repeat (4) tick();
        n_cmp++;
        if (fa !== 1'b1) begin n_bad++; $display("FAIL mid_fire: got %b want 1", fa); end
        ra = 0;
        tick();
        n_cmp++;
        if ({ca, wa, fa, ea} !== 35'd0) begin n_bad++; $display("FAIL mid_reset: got %h want 0", {ca, wa, fa, ea}); end
        la = 2; ra = 1;
        for (int e = 0; e <= 2; e++) begin
            tick();
            n_cmp++;
            if ({ca, fa, ea} !== {32'(e), e == 2, e == 2})
                begin n_bad++; $display("FAIL mid_rel_e%0d: count/fire/exp got %0d/%b/%b", e, ca, fa, ea); end
        end
    endtask

    task automatic test_width();
        restart(2, 15);
        tick();
        for (int i = 1; i <= 18; i++) begin
            tick();
            n_cmp++;
            if ({cc, fc, ec} !== {4'(i > 15 ? 15 : i), i == 15, i >= 15})
                begin n_bad++; $display("FAIL width_e%0d: count/fire/exp got %0d/%b/%b", i, cc, fc, ec); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            restart(0, longint'($urandom_range(0, 30)));
            restart(1, longint'($urandom_range(0, 12)));
            restart(2, longint'($urandom_range(0, 15)));
            for (int n = 0; n < 150; n++) begin
                ka = ($urandom_range(0, 9) == 0); pa = ($urandom_range(0, 4) == 0);
                kb = ($urandom_range(0, 19) == 0); pb = ($urandom_range(0, 4) == 0);
                kc = ($urandom_range(0, 9) == 0); pc = ($urandom_range(0, 4) == 0);
                ra = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 19) == 0) la = $urandom_range(0, 30);
                tick();
                n_cmp++;
                if ({ca, wa, fa, ea} !== {mc[0][31:0], mw[0], mf[0], me[0]})
                    begin n_bad++; $display("FAIL rand_a: got %h want %h", {ca, wa, fa, ea}, {mc[0][31:0], mw[0], mf[0], me[0]}); end
                n_cmp++;
                if ({cb, wb, fb, eb} !== {mc[1][31:0], mw[1], mf[1], me[1]})
                    begin n_bad++; $display("FAIL rand_b: got %h want %h", {cb, wb, fb, eb}, {mc[1][31:0], mw[1], mf[1], me[1]}); end
                n_cmp++;
                if ({cc, wc, fc, ec} !== {mc[2][3:0], mw[2], mf[2], me[2]})
                    begin n_bad++; $display("FAIL rand_c: got %h want %h", {cc, wc, fc, ec}, {mc[2][3:0], mw[2], mf[2], me[2]}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_disabled();
        test_kick_race();
        test_prescale_warn();
        test_reset_mid();
        test_width();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
